// File: rtl/gpio_pattern_seq_if.sv
// Bundle of the ic0 config-slave port and the sequencer's GPIO write-master port.
// Port summary: CPU write/read strobes, address and data in; read ready/data out;
//   seq_wr_* master request out, seq_wr_grant in; seq_busy and seq_done status out.
interface gpio_pattern_seq_if;
   logic        ic0_c_axi_mst_wr_valid;
   logic [31:0] ic0_axi_mst_wr_addr;
   logic [31:0] ic0_axi_mst_wr_data;
   logic        ic0_c_axi_mst_rd_valid;
   logic [31:0] ic0_axi_mst_rd_addr;
   logic        ic0_c_axi_slv_rd_ready_2;
   logic [31:0] ic0_axi_slv_rd_data_2;
   logic        seq_wr_valid;
   logic [31:0] seq_wr_addr;
   logic [31:0] seq_wr_data;
   logic        seq_wr_grant;
   logic        seq_busy;
   logic        seq_done;

   // Sequencer side: slave on the config bus, master towards the GPIO arbiter.
   modport slave (
      input  ic0_c_axi_mst_wr_valid, ic0_axi_mst_wr_addr, ic0_axi_mst_wr_data,
      input  ic0_c_axi_mst_rd_valid, ic0_axi_mst_rd_addr,
      output ic0_c_axi_slv_rd_ready_2, ic0_axi_slv_rd_data_2,
      output seq_wr_valid, seq_wr_addr, seq_wr_data,
      input  seq_wr_grant,
      output seq_busy, seq_done
   );

   // Environment side: CPU plus arbiter.
   modport master (
      output ic0_c_axi_mst_wr_valid, ic0_axi_mst_wr_addr, ic0_axi_mst_wr_data,
      output ic0_c_axi_mst_rd_valid, ic0_axi_mst_rd_addr,
      input  ic0_c_axi_slv_rd_ready_2, ic0_axi_slv_rd_data_2,
      input  seq_wr_valid, seq_wr_addr, seq_wr_data,
      output seq_wr_grant,
      input  seq_busy, seq_done
   );
endinterface

// File: rtl/gpio_pattern_seq.sv
// GPIO pattern sequencer: replays a {value, hold} table as OUT_CLR/OUT_SET writes to a GPIO block.
// Latency: START write in cycle N gives seq_wr_valid in N+1; entry period = 2 + hold with grant high.
// Backpressure: a write request holds valid/addr/data stable until seq_wr_grant; config port never stalls.
// Ports: clk, c_sys_rst_n (async active-low), bus (config slave + GPIO write master, see interface).
module gpio_pattern_seq #(
   parameter logic [31:0] CFG_BASE  = 32'h8003_0200,
   parameter logic [31:0] GPIO_BASE = 32'h8003_0100,
   parameter int          DEPTH     = 8,
   parameter int          HOLD_W    = 16
) (
   input  logic              clk,
   input  logic              c_sys_rst_n,
   gpio_pattern_seq_if.slave bus
);
   localparam int          IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int          EW       = 8 + HOLD_W;
   localparam logic [4:0]  LEN_MAX  = 5'(DEPTH);
   localparam logic [31:0] CLR_ADDR = GPIO_BASE + 32'h10;
   localparam logic [31:0] SET_ADDR = GPIO_BASE + 32'h14;

   typedef enum logic [1:0] {S_IDLE, S_CLR, S_SET, S_HOLD} state_t;

   state_t              r_state, w_state_nxt;
   logic [EW-1:0]       r_tbl [DEPTH];
   logic [4:0]          r_len;
   logic                r_loop, r_sticky, r_done, w_done_nxt;
   logic [3:0]          r_idx, w_idx_nxt, w_lat_idx;
   logic [7:0]          r_val;
   logic [HOLD_W-1:0]   r_hold, r_cnt, w_cnt_nxt, w_hold_m1;
   logic                r_stop_pend, w_stop_pend_nxt;
   logic                r_wr_valid, w_vld_nxt, w_latch, w_adv, w_go;
   logic [31:0]         r_wr_addr, w_addr_nxt, r_wr_data, w_data_nxt;
   logic [EW-1:0]       w_lat_ent;
   logic [31:0]         w_woff, w_roff, w_rd_dat;
   logic                w_wr_hit, w_ctrl_wr, w_len_wr, w_ent_wr, w_start, w_stop, w_rd_rdy, w_busy;
   logic                w_unused;

   // Register window: word-aligned offsets 0x00..0xFF from CFG_BASE.
   function automatic logic in_region(input logic [31:0] off);
      return (off[31:8] == 24'd0) && (off[1:0] == 2'b00);
   endfunction

   function automatic logic is_entry(input logic [31:0] off);
      return (off[7:6] == 2'b01) && ({1'b0, off[5:2]} < LEN_MAX);
   endfunction

   assign w_woff    = bus.ic0_axi_mst_wr_addr - CFG_BASE;
   assign w_roff    = bus.ic0_axi_mst_rd_addr - CFG_BASE;
   assign w_wr_hit  = bus.ic0_c_axi_mst_wr_valid && in_region(w_woff);
   assign w_ctrl_wr = w_wr_hit && (w_woff[7:0] == 8'h00);
   assign w_len_wr  = w_wr_hit && (w_woff[7:0] == 8'h08);
   assign w_ent_wr  = w_wr_hit && is_entry(w_woff);
   // STOP takes priority over START within one CTRL write.
   assign w_start   = w_ctrl_wr && bus.ic0_axi_mst_wr_data[0] && !bus.ic0_axi_mst_wr_data[1];
   assign w_stop    = w_ctrl_wr && bus.ic0_axi_mst_wr_data[1];
   assign w_unused  = ^bus.ic0_axi_mst_wr_data[31:EW];

   assign w_busy = (r_state != S_IDLE);
   assign w_go   = (r_state == S_IDLE) && w_start && (r_len != 5'd0);

   // Entry to latch on the next CLR: idx+1 when continuing from HOLD, otherwise restart at 0.
   // LEN is compared live so a shortened table ends the run after the current entry.
   assign w_adv     = ({1'b0, r_idx} + 5'd1) < r_len;
   assign w_lat_idx = (r_state == S_HOLD && w_adv) ? (r_idx + 4'd1) : 4'd0;
   assign w_lat_ent = r_tbl[w_lat_idx[IW-1:0]];
   // Hold 0 behaves as hold 1.
   assign w_hold_m1 = (r_hold == '0) ? '0 : (r_hold - HOLD_W'(1));

   always_comb begin
      w_state_nxt     = r_state;
      w_idx_nxt       = r_idx;
      w_cnt_nxt       = r_cnt;
      w_stop_pend_nxt = r_stop_pend;
      w_vld_nxt       = r_wr_valid;
      w_addr_nxt      = r_wr_addr;
      w_data_nxt      = r_wr_data;
      w_done_nxt      = 1'b0;
      w_latch         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_go) begin
               w_state_nxt     = S_CLR;
               w_idx_nxt       = 4'd0;
               w_latch         = 1'b1;
               w_stop_pend_nxt = 1'b0;
               w_vld_nxt       = 1'b1;
               w_addr_nxt      = CLR_ADDR;
               w_data_nxt      = {24'd0, ~w_lat_ent[7:0]};
            end
         end
         S_CLR, S_SET: begin
            // A STOP here must not abandon the outstanding request; remember it until grant.
            if (w_stop) w_stop_pend_nxt = 1'b1;
            if (bus.seq_wr_grant) begin
               if (r_stop_pend || w_stop) begin
                  w_state_nxt     = S_IDLE;
                  w_stop_pend_nxt = 1'b0;
                  w_vld_nxt       = 1'b0;
                  w_addr_nxt      = '0;
                  w_data_nxt      = '0;
                  w_done_nxt      = 1'b1;
               end else if (r_state == S_CLR) begin
                  w_state_nxt = S_SET;
                  w_addr_nxt  = SET_ADDR;
                  w_data_nxt  = {24'd0, r_val};
               end else begin
                  w_state_nxt = S_HOLD;
                  w_vld_nxt   = 1'b0;
                  w_addr_nxt  = '0;
                  w_data_nxt  = '0;
                  w_cnt_nxt   = w_hold_m1;
               end
            end
         end
         S_HOLD: begin
            if (w_stop) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end else if (r_cnt == '0) begin
               if (w_adv || (r_loop && r_len != 5'd0)) begin
                  w_state_nxt = S_CLR;
                  w_idx_nxt   = w_lat_idx;
                  w_latch     = 1'b1;
                  w_vld_nxt   = 1'b1;
                  w_addr_nxt  = CLR_ADDR;
                  w_data_nxt  = {24'd0, ~w_lat_ent[7:0]};
               end else begin
                  w_state_nxt = S_IDLE;
                  w_done_nxt  = 1'b1;
               end
            end else begin
               w_cnt_nxt = r_cnt - HOLD_W'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge c_sys_rst_n) begin
      if (!c_sys_rst_n) r_state <= S_IDLE;
      else              r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge c_sys_rst_n) begin
      if (!c_sys_rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_tbl[i] <= '0;
         r_len       <= '0;
         r_loop      <= 1'b0;
         r_sticky    <= 1'b0;
         r_done      <= 1'b0;
         r_idx       <= '0;
         r_val       <= '0;
         r_hold      <= '0;
         r_cnt       <= '0;
         r_stop_pend <= 1'b0;
         r_wr_valid  <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
      end else begin
         if (w_ctrl_wr) r_loop <= bus.ic0_axi_mst_wr_data[2];
         if (w_len_wr)
            r_len <= (bus.ic0_axi_mst_wr_data[4:0] > LEN_MAX) ? LEN_MAX : bus.ic0_axi_mst_wr_data[4:0];
         if (w_ent_wr) r_tbl[w_woff[IW+1:2]] <= bus.ic0_axi_mst_wr_data[EW-1:0];
         if (w_latch) begin
            r_val  <= w_lat_ent[7:0];
            r_hold <= w_lat_ent[EW-1:8];
         end
         if (w_go)            r_sticky <= 1'b0;
         else if (w_done_nxt) r_sticky <= 1'b1;
         r_done      <= w_done_nxt;
         r_idx       <= w_idx_nxt;
         r_cnt       <= w_cnt_nxt;
         r_stop_pend <= w_stop_pend_nxt;
         r_wr_valid  <= w_vld_nxt;
         r_wr_addr   <= w_addr_nxt;
         r_wr_data   <= w_data_nxt;
      end
   end

   // Combinational read port: ready only on a mapped register.
   always_comb begin
      w_rd_rdy = 1'b0;
      w_rd_dat = '0;
      if (bus.ic0_c_axi_mst_rd_valid && in_region(w_roff)) begin
         if (w_roff[7:0] == 8'h00) begin
            w_rd_rdy = 1'b1;
            w_rd_dat = {31'd0, r_loop};
         end else if (w_roff[7:0] == 8'h04) begin
            w_rd_rdy = 1'b1;
            w_rd_dat = {23'd0, r_sticky, r_idx, 3'd0, w_busy};
         end else if (w_roff[7:0] == 8'h08) begin
            w_rd_rdy = 1'b1;
            w_rd_dat = {27'd0, r_len};
         end else if (is_entry(w_roff)) begin
            w_rd_rdy = 1'b1;
            w_rd_dat = {{(32-EW){1'b0}}, r_tbl[w_roff[IW+1:2]]};
         end
      end
   end

   assign bus.ic0_c_axi_slv_rd_ready_2 = w_rd_rdy;
   assign bus.ic0_axi_slv_rd_data_2    = w_rd_dat;
   assign bus.seq_wr_valid             = r_wr_valid;
   assign bus.seq_wr_addr              = r_wr_addr;
   assign bus.seq_wr_data              = r_wr_data;
   assign bus.seq_busy                 = w_busy;
   assign bus.seq_done                 = r_done;
endmodule

// File: tb/tb_gpio_pattern_seq.sv
module tb_gpio_pattern_seq;
   localparam logic [31:0] A_CTRL = 32'h8003_0200;
   localparam logic [31:0] A_STAT = 32'h8003_0204;
   localparam logic [31:0] A_LEN  = 32'h8003_0208;
   localparam logic [31:0] A_E0   = 32'h8003_0240;
   localparam logic [31:0] A_E1   = 32'h8003_0244;
   localparam logic [31:0] G_CLR  = 32'h8003_0110;
   localparam logic [31:0] G_SET  = 32'h8003_0114;

   logic clk = 1'b0;
   logic c_sys_rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic        rrdy;
   logic [31:0] rdat;

   gpio_pattern_seq_if bus ();

   gpio_pattern_seq #(
      .CFG_BASE (32'h8003_0200),
      .GPIO_BASE(32'h8003_0100),
      .DEPTH    (8),
      .HOLD_W   (16)
   ) dut (
      .clk        (clk),
      .c_sys_rst_n(c_sys_rst_n),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_wr(input logic [31:0] a, input logic [31:0] d);
      bus.ic0_c_axi_mst_wr_valid = 1'b1;
      bus.ic0_axi_mst_wr_addr    = a;
      bus.ic0_axi_mst_wr_data    = d;
      tick();
      bus.ic0_c_axi_mst_wr_valid = 1'b0;
   endtask

   task automatic cpu_rd(input logic [31:0] a, output logic r, output logic [31:0] d);
      bus.ic0_c_axi_mst_rd_valid = 1'b1;
      bus.ic0_axi_mst_rd_addr    = a;
      #1;
      r = bus.ic0_c_axi_slv_rd_ready_2;
      d = bus.ic0_axi_slv_rd_data_2;
      bus.ic0_c_axi_mst_rd_valid = 1'b0;
   endtask

   task automatic chk_wr(input string tag, input logic v, input logic [31:0] a, input logic [31:0] d);
      check({tag, ".valid"}, {31'd0, bus.seq_wr_valid}, {31'd0, v});
      check({tag, ".addr"}, bus.seq_wr_addr, a);
      check({tag, ".data"}, bus.seq_wr_data, d);
   endtask

   initial begin
      bus.ic0_c_axi_mst_wr_valid = 1'b0;
      bus.ic0_axi_mst_wr_addr    = '0;
      bus.ic0_axi_mst_wr_data    = '0;
      bus.ic0_c_axi_mst_rd_valid = 1'b0;
      bus.ic0_axi_mst_rd_addr    = '0;
      bus.seq_wr_grant           = 1'b1;
      #22;
      c_sys_rst_n = 1'b1;
      tick();

      // Reset state
      chk_wr("rst", 1'b0, 32'h0, 32'h0);
      check("rst.busy", {31'd0, bus.seq_busy}, 32'd0);
      check("rst.done", {31'd0, bus.seq_done}, 32'd0);
      cpu_rd(A_STAT, rrdy, rdat);
      check("rst.stat", rdat, 32'h0);

      // 1: two-entry one-shot with grant high
      cpu_wr(A_LEN, 32'd2);
      cpu_wr(A_E0, 32'h0000_035A);
      cpu_wr(A_E1, 32'h0000_010F);
      cpu_rd(A_E0, rrdy, rdat);
      check("t1.e0_rb", rdat, 32'h0000_035A);
      cpu_wr(A_CTRL, 32'h1);
      chk_wr("t1.clr0", 1'b1, G_CLR, 32'hA5);
      tick(); chk_wr("t1.set0", 1'b1, G_SET, 32'h5A);
      tick(); check("t1.hold_a", {31'd0, bus.seq_wr_valid}, 32'd0);
      tick(); check("t1.hold_b", {31'd0, bus.seq_wr_valid}, 32'd0);
      tick(); check("t1.hold_c", {31'd0, bus.seq_wr_valid}, 32'd0);
      tick(); chk_wr("t1.clr1", 1'b1, G_CLR, 32'hF0);
      tick(); chk_wr("t1.set1", 1'b1, G_SET, 32'h0F);
      tick(); check("t1.hold1", {31'd0, bus.seq_wr_valid}, 32'd0);
      cpu_rd(A_STAT, rrdy, rdat);
      check("t1.stat_busy", rdat, 32'h11);
      tick();
      check("t1.done", {31'd0, bus.seq_done}, 32'd1);
      check("t1.busy", {31'd0, bus.seq_busy}, 32'd0);
      tick();
      check("t1.done_pulse", {31'd0, bus.seq_done}, 32'd0);
      cpu_rd(A_STAT, rrdy, rdat);
      check("t1.stat_end", rdat, 32'h110);

      // 2: grant low 5 cycles during CLR
      cpu_wr(A_LEN, 32'd1);
      bus.seq_wr_grant = 1'b0;
      cpu_wr(A_CTRL, 32'h1);
      chk_wr("t2.clr_c0", 1'b1, G_CLR, 32'hA5);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_wr("t2.clr_stall", 1'b1, G_CLR, 32'hA5);
      end
      bus.seq_wr_grant = 1'b1;
      tick(); chk_wr("t2.set", 1'b1, G_SET, 32'h5A);
      tick(); tick(); tick();
      check("t2.busy_hold", {31'd0, bus.seq_busy}, 32'd1);
      tick();
      check("t2.done", {31'd0, bus.seq_done}, 32'd1);

      // 3: loop with hold 0, STOP in HOLD
      cpu_wr(A_E0, 32'h0000_003C);
      cpu_wr(A_CTRL, 32'h5);
      chk_wr("t3.clr_a", 1'b1, G_CLR, 32'hC3);
      tick(); chk_wr("t3.set_a", 1'b1, G_SET, 32'h3C);
      tick(); check("t3.hold_a", {31'd0, bus.seq_wr_valid}, 32'd0);
      tick(); chk_wr("t3.clr_b", 1'b1, G_CLR, 32'hC3);
      tick(); chk_wr("t3.set_b", 1'b1, G_SET, 32'h3C);
      tick(); check("t3.hold_b", {31'd0, bus.seq_wr_valid}, 32'd0);
      cpu_wr(A_CTRL, 32'h6);
      check("t3.stop_busy", {31'd0, bus.seq_busy}, 32'd0);
      check("t3.stop_done", {31'd0, bus.seq_done}, 32'd1);
      check("t3.stop_vld", {31'd0, bus.seq_wr_valid}, 32'd0);
      tick();
      check("t3.after_vld", {31'd0, bus.seq_wr_valid}, 32'd0);
      cpu_rd(A_CTRL, rrdy, rdat);
      check("t3.loop_rb", rdat, 32'h1);
      cpu_wr(A_CTRL, 32'h0);

      // 4: STOP in SET with grant low
      cpu_wr(A_E0, 32'h0000_035A);
      cpu_wr(A_CTRL, 32'h1);
      tick(); chk_wr("t4.set", 1'b1, G_SET, 32'h5A);
      bus.seq_wr_grant = 1'b0;
      cpu_wr(A_CTRL, 32'h2);
      chk_wr("t4.set_wait", 1'b1, G_SET, 32'h5A);
      check("t4.busy_wait", {31'd0, bus.seq_busy}, 32'd1);
      tick(); chk_wr("t4.set_wait2", 1'b1, G_SET, 32'h5A);
      bus.seq_wr_grant = 1'b1;
      tick();
      check("t4.done", {31'd0, bus.seq_done}, 32'd1);
      check("t4.vld", {31'd0, bus.seq_wr_valid}, 32'd0);
      tick();
      check("t4.idle_busy", {31'd0, bus.seq_busy}, 32'd0);
      tick();
      check("t4.idle_vld", {31'd0, bus.seq_wr_valid}, 32'd0);

      // 5: LEN=0 start no-op, LEN clamp, unmapped reads
      cpu_wr(A_LEN, 32'd0);
      cpu_wr(A_CTRL, 32'h1);
      check("t5.vld", {31'd0, bus.seq_wr_valid}, 32'd0);
      check("t5.busy", {31'd0, bus.seq_busy}, 32'd0);
      tick();
      check("t5.vld2", {31'd0, bus.seq_wr_valid}, 32'd0);
      cpu_wr(A_LEN, 32'd20);
      cpu_rd(A_LEN, rrdy, rdat);
      check("t5.len_rdy", {31'd0, rrdy}, 32'd1);
      check("t5.len_clamp", rdat, 32'd8);
      cpu_rd(32'h8003_023C, rrdy, rdat);
      check("t5.unmap_rdy", {31'd0, rrdy}, 32'd0);
      check("t5.unmap_dat", rdat, 32'd0);
      cpu_rd(32'h8003_0260, rrdy, rdat);
      check("t5.beyond_rdy", {31'd0, rrdy}, 32'd0);

      // 6: reset mid-HOLD
      cpu_wr(A_LEN, 32'd1);
      cpu_wr(A_E0, 32'h0000_0A11);
      cpu_wr(A_CTRL, 32'h1);
      chk_wr("t6.clr", 1'b1, G_CLR, 32'hEE);
      tick(); tick(); tick();
      check("t6.in_hold", {31'd0, bus.seq_busy}, 32'd1);
      c_sys_rst_n = 1'b0;
      #1;
      check("t6.rst_vld", {31'd0, bus.seq_wr_valid}, 32'd0);
      check("t6.rst_busy", {31'd0, bus.seq_busy}, 32'd0);
      check("t6.rst_done", {31'd0, bus.seq_done}, 32'd0);
      cpu_rd(A_STAT, rrdy, rdat);
      check("t6.rst_stat", rdat, 32'd0);
      cpu_rd(A_E0, rrdy, rdat);
      check("t6.rst_tbl", rdat, 32'd0);
      cpu_rd(A_LEN, rrdy, rdat);
      check("t6.rst_len", rdat, 32'd0);
      c_sys_rst_n = 1'b1;
      tick();
      cpu_wr(A_CTRL, 32'h1);
      check("t6.post_vld", {31'd0, bus.seq_wr_valid}, 32'd0);
      check("t6.post_busy", {31'd0, bus.seq_busy}, 32'd0);
      tick();
      check("t6.post_done", {31'd0, bus.seq_done}, 32'd0);
      cpu_rd(A_STAT, rrdy, rdat);
      check("t6.post_stat", rdat, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
